// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader and run/step controller for the mips core.
// Assembles little-endian words from a valid/ready byte stream into instruction
// memory while holding the core in reset, then gates core execution until halt.
module imem_loader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [31:0]           imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_reset,
   output logic                  cpu_en,
   input  logic                  cpu_halt,
   output logic                  load_done,
   output logic                  halted,
   output logic                  overflow,
   output logic [31:0]           run_cycles
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BYTE_W = 8;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_WRITE,
      S_RUN,
      S_STEP
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        word_idx_q, word_idx_d;
   logic [1:0]              byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic                    last_q, last_d;
   logic                    rx_ready_q, rx_ready_d;
   logic                    imem_we_q, imem_we_d;
   logic [31:0]             imem_addr_q, imem_addr_d;
   logic [DATA_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;
   logic                    cpu_reset_q, cpu_reset_d;
   logic                    cpu_en_q, cpu_en_d;
   logic                    load_done_q, load_done_d;
   logic                    halted_q, halted_d;
   logic                    overflow_q, overflow_d;
   logic [31:0]             run_cycles_q, run_cycles_d;

   logic                    accept;
   logic [DATA_WIDTH-1:0]   shifted_word;
   logic [CNT_W-1:0]        cnt_full;

   assign accept       = rx_valid & rx_ready_q;
   assign shifted_word = {rx_data, word_q[DATA_WIDTH-1:BYTE_W]};
   assign cnt_full     = {rx_data, cnt_q[BYTE_W-1:0]};

   // Next-state and next-output computation for the load/run controller
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      word_idx_d   = word_idx_q;
      byte_cnt_d   = byte_cnt_q;
      word_d       = word_q;
      last_d       = last_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      cpu_reset_d  = cpu_reset_q;
      cpu_en_d     = 1'b0;
      load_done_d  = 1'b0;
      halted_d     = halted_q;
      overflow_d   = overflow_q;
      run_cycles_d = run_cycles_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (rx_data)
                  CMD_LOAD: begin
                     state_d      = S_CNT_LO;
                     cpu_reset_d  = 1'b1;
                     halted_d     = 1'b0;
                     overflow_d   = 1'b0;
                     run_cycles_d = 32'd0;
                  end
                  CMD_RUN: begin
                     if (!halted_q) begin
                        state_d  = S_RUN;
                        cpu_en_d = 1'b1;
                     end
                  end
                  CMD_STEP: begin
                     if (!halted_q) begin
                        state_d  = S_STEP;
                        cpu_en_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end

         S_CNT_LO: begin
            if (accept) begin
               cnt_d[BYTE_W-1:0] = rx_data;
               state_d           = S_CNT_HI;
            end
         end

         S_CNT_HI: begin
            if (accept) begin
               cnt_d = cnt_full;
               if (cnt_full == CNT_W'(0)) begin
                  // Empty program: release the core without touching memory
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
                  cpu_reset_d = 1'b0;
               end else begin
                  state_d    = S_DATA;
                  byte_cnt_d = 2'd0;
                  word_idx_d = CNT_W'(0);
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               word_d     = shifted_word;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = S_WRITE;
                  last_d  = ((CNT_W + 1)'(word_idx_q) + (CNT_W + 1)'(1)) ==
                            (CNT_W + 1)'(cnt_q);
                  // Write strobe, address and data are launched so they land in the WRITE cycle
                  if (32'(word_idx_q) < MAX_WORDS) begin
                     imem_we_d    = 1'b1;
                     imem_addr_d  = {14'd0, word_idx_q, 2'b00};
                     imem_wdata_d = shifted_word;
                  end else begin
                     overflow_d = 1'b1;
                  end
                  load_done_d = last_d;
               end
            end
         end

         S_WRITE: begin
            word_idx_d = word_idx_q + CNT_W'(1);
            if (last_q) begin
               state_d     = S_IDLE;
               cpu_reset_d = 1'b0;
            end else begin
               state_d = S_DATA;
            end
         end

         S_RUN: begin
            if (cpu_halt) begin
               state_d  = S_IDLE;
               halted_d = 1'b1;
            end else begin
               cpu_en_d = 1'b1;
            end
         end

         S_STEP: begin
            state_d = S_IDLE;
            if (cpu_halt) begin
               halted_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Count every cycle the core is enabled; wraps naturally at 2^32
      if (cpu_en_d) begin
         run_cycles_d = run_cycles_q + 32'd1;
      end

      rx_ready_d = (state_d == S_IDLE) || (state_d == S_CNT_LO) ||
                   (state_d == S_CNT_HI) || (state_d == S_DATA);
   end

   // State and registered-output flops with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         word_idx_q   <= '0;
         byte_cnt_q   <= '0;
         word_q       <= '0;
         last_q       <= 1'b0;
         rx_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_reset_q  <= 1'b1;
         cpu_en_q     <= 1'b0;
         load_done_q  <= 1'b0;
         halted_q     <= 1'b0;
         overflow_q   <= 1'b0;
         run_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         word_idx_q   <= word_idx_d;
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         last_q       <= last_d;
         rx_ready_q   <= rx_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         cpu_en_q     <= cpu_en_d;
         load_done_q  <= load_done_d;
         halted_q     <= halted_d;
         overflow_q   <= overflow_d;
         run_cycles_q <= run_cycles_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign cpu_en     = cpu_en_q;
   assign load_done  = load_done_q;
   assign halted     = halted_q;
   assign overflow   = overflow_q;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized bench for imem_loader with a small
// behavioural model of loads, runs and steps.
module tb_imem_loader;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        cpu_en;
   logic        cpu_halt;
   logic        load_done;
   logic        halted;
   logic        overflow;
   logic [31:0] run_cycles;

   imem_loader #(.DATA_WIDTH(32), .MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .cpu_en     (cpu_en),
      .cpu_halt   (cpu_halt),
      .load_done  (load_done),
      .halted     (halted),
      .overflow   (overflow),
      .run_cycles (run_cycles)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Observed activity, sampled on the falling edge
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          en_cnt  = 0;
   int          en_adj  = 0;
   int          ld_cnt  = 0;
   logic        prev_en = 1'b0;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
      if (cpu_en === 1'b1) begin
         en_cnt++;
         if (prev_en) en_adj++;
      end
      if (load_done === 1'b1) ld_cnt++;
      prev_en = (cpu_en === 1'b1);
   end

   logic [31:0] exp_words[$];
   int          exp_runc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the byte was accepted
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("rx_ready_timeout", 32'(t), 32'd0);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Sends a full load frame of exp_words and checks the resulting writes
   task automatic do_load();
      int          n;
      int          base;
      int          ld0;
      int          nexp;
      logic [31:0] w;
      n    = exp_words.size();
      base = wr_addr.size();
      ld0  = ld_cnt;
      send_byte(8'h4C);
      send_byte(8'(n));
      send_byte(8'(n >> 8));
      if (n == 0) chk("load_done_n0", 32'(load_done), 32'd1);
      for (int i = 0; i < n; i++) begin
         w = exp_words[i];
         for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
         chk($sformatf("we_w%0d", i), 32'(imem_we), 32'(i < MAXW));
         chk($sformatf("load_done_w%0d", i), 32'(load_done), 32'(i == n - 1));
         if (i == n - 1) chk("cpu_reset_at_last_write", 32'(cpu_reset), 32'd1);
      end
      idle(2);
      nexp = (n < MAXW) ? n : MAXW;
      chk("num_writes", 32'(wr_addr.size() - base), 32'(nexp));
      for (int i = 0; i < nexp && base + i < wr_addr.size(); i++) begin
         chk($sformatf("addr_w%0d", i), wr_addr[base + i], 32'(i * 4));
         chk($sformatf("data_w%0d", i), wr_data[base + i], exp_words[i]);
      end
      chk("load_done_pulses", 32'(ld_cnt - ld0), 32'd1);
      chk("cpu_reset_after_load", 32'(cpu_reset), 32'd0);
      chk("overflow_after_load", 32'(overflow), 32'(n > MAXW));
      chk("halted_after_load", 32'(halted), 32'd0);
      chk("run_cycles_after_load", run_cycles, 32'd0);
      exp_runc = 0;
   endtask

   task automatic rand_words(input int n);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
   endtask

   // Free-run until k enabled cycles have been seen, then raise halt
   task automatic run_for(input int k);
      int e0;
      int c = 0;
      int t = 0;
      e0 = en_cnt;
      send_byte(8'h52);
      while (c < k && t < 200) begin
         if (cpu_en === 1'b1) c++;
         if (c == k) cpu_halt = 1'b1;
         @(negedge clk);
         t++;
      end
      cpu_halt = 1'b0;
      chk("run_en_low_after_halt", 32'(cpu_en), 32'd0);
      idle(2);
      exp_runc += k;
      chk("run_en_cycles", 32'(en_cnt - e0), 32'(k));
      chk("run_cycles_after_run", run_cycles, 32'(exp_runc));
      chk("halted_after_run", 32'(halted), 32'd1);
   endtask

   initial begin
      int k;
      int e0;
      int a0;
      logic [7:0] junk;
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      cpu_halt = 1'b0;
      exp_runc = 0;
      idle(3);

      // Reset values
      chk("rst_rx_ready", 32'(rx_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_run_cycles", run_cycles, 32'd0);
      reset = 1'b0;
      idle(2);
      chk("idle_rx_ready", 32'(rx_ready), 32'd1);
      chk("idle_cpu_reset_held", 32'(cpu_reset), 32'd1);

      // Fixed two-word frame
      exp_words.delete();
      exp_words.push_back(32'h12345678);
      exp_words.push_back(32'hDEADBEEF);
      do_load();

      // Run for 10 cycles, then confirm run/step are ignored once halted
      run_for(10);
      e0 = en_cnt;
      send_byte(8'h52);
      send_byte(8'h53);
      idle(3);
      chk("halted_ignores_cmds_en", 32'(en_cnt - e0), 32'd0);
      chk("halted_ignores_cmds_cycles", run_cycles, 32'(exp_runc));

      // Empty program
      exp_words.delete();
      do_load();

      // Non-command bytes are swallowed in idle
      for (int i = 0; i < 3; i++) begin
         junk = 8'($urandom);
         if (junk == 8'h4C || junk == 8'h52 || junk == 8'h53) junk = 8'h00;
         e0 = en_cnt;
         send_byte(junk);
         idle(1);
         chk("junk_no_en", 32'(en_cnt - e0), 32'd0);
         chk("junk_rx_ready", 32'(rx_ready), 32'd1);
      end

      // Random program, then three single steps
      rand_words($urandom_range(1, MAXW));
      do_load();
      e0 = en_cnt;
      a0 = en_adj;
      for (int s = 0; s < 3; s++) begin
         send_byte(8'h53);
         chk("step_en_pulse", 32'(cpu_en), 32'd1);
      end
      idle(2);
      exp_runc += 3;
      chk("step_en_count", 32'(en_cnt - e0), 32'd3);
      chk("step_isolated", 32'(en_adj - a0), 32'd0);
      chk("step_run_cycles", run_cycles, 32'(exp_runc));
      chk("step_not_halted", 32'(halted), 32'd0);

      // A step with halt present latches halted
      cpu_halt = 1'b1;
      send_byte(8'h53);
      idle(1);
      cpu_halt = 1'b0;
      idle(1);
      exp_runc += 1;
      chk("step_halt_latched", 32'(halted), 32'd1);
      chk("step_halt_run_cycles", run_cycles, 32'(exp_runc));

      // Overflow: more words than memory holds
      rand_words(MAXW + 2);
      do_load();

      // Random-length runs after fresh loads
      for (int r = 0; r < 2; r++) begin
         rand_words($urandom_range(1, MAXW));
         do_load();
         k = $urandom_range(1, 20);
         run_for(k);
      end

      // Reset in the middle of a word discards all progress
      send_byte(8'h4C);
      send_byte(8'd1);
      send_byte(8'd0);
      send_byte(8'hAA);
      send_byte(8'hBB);
      a0 = wr_addr.size();
      reset = 1'b1;
      idle(2);
      chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
      chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("midrst_imem_we", 32'(imem_we), 32'd0);
      chk("midrst_imem_addr", imem_addr, 32'd0);
      chk("midrst_imem_wdata", imem_wdata, 32'd0);
      chk("midrst_run_cycles", run_cycles, 32'd0);
      chk("midrst_halted", 32'(halted), 32'd0);
      reset = 1'b0;
      idle(2);
      chk("midrst_no_write", 32'(wr_addr.size() - a0), 32'd0);
      rand_words(2);
      do_load();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
